// File: rtl/pvr_param_pkg.sv
// Shared polygon-parameter layout constants for the TA writer and the ISP parser.
// Holds ISP decode bits, word-count constants, vertex slot order and writer states.
package pvr_param_pkg;

  localparam int unsigned IspTextureBit = 25;
  localparam int unsigned IspOffsetBit  = 24;
  localparam int unsigned IspUv16Bit    = 22;

  localparam logic [2:0] HdrWordsPlain  = 3'd3;
  localparam logic [2:0] HdrWordsShadow = 3'd5;
  localparam logic [2:0] VtxWordsBase   = 3'd4;

  // Vertex slot order as the parser walks it.
  localparam logic [2:0] SlotX    = 3'd0;
  localparam logic [2:0] SlotY    = 3'd1;
  localparam logic [2:0] SlotZ    = 3'd2;
  localparam logic [2:0] SlotU0   = 3'd3;
  localparam logic [2:0] SlotV0   = 3'd4;
  localparam logic [2:0] SlotBase = 3'd5;
  localparam logic [2:0] SlotOff  = 3'd6;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdr   = 3'd1;
  localparam logic [2:0] StVwait = 3'd2;
  localparam logic [2:0] StVword = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  function automatic logic [2:0] vtx_words(logic tex, logic off, logic uv16);
    logic [2:0] w;
    w = VtxWordsBase;
    if (tex) w = w + (uv16 ? 3'd1 : 3'd2);
    if (off) w = w + 3'd1;
    return w;
  endfunction

  function automatic logic slot_present(logic [2:0] slot, logic tex, logic off, logic uv16);
    case (slot)
      SlotU0:  return tex;
      SlotV0:  return tex & ~uv16;
      SlotOff: return off;
      3'd7:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ta_word_sel.sv
// Vertex word mux: selects the word for the current slot and finds the next
// slot present for this polygon type.
module ta_word_sel
  import pvr_param_pkg::*;
(
  input  logic [2:0]       idx_i,
  input  logic             texture_i,
  input  logic             offset_i,
  input  logic             uv16_i,
  input  logic [6:0][31:0] words_i,
  output logic [31:0]      data_o,
  output logic [2:0]       next_idx_o,
  output logic             last_o
);

  always_comb begin
    case (idx_i)
      3'd0:    data_o = words_i[0];
      3'd1:    data_o = words_i[1];
      3'd2:    data_o = words_i[2];
      3'd3:    data_o = words_i[3];
      3'd4:    data_o = words_i[4];
      3'd5:    data_o = words_i[5];
      3'd6:    data_o = words_i[6];
      default: data_o = 32'h0;
    endcase
  end

  // Scan downwards so the lowest present slot above idx_i wins.
  always_comb begin
    next_idx_o = idx_i;
    last_o     = 1'b1;
    for (int i = 6; i >= 1; i--) begin
      if (3'(i) > idx_i && slot_present(3'(i), texture_i, offset_i, uv16_i)) begin
        next_idx_o = 3'(i);
        last_o     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ta_param_writer.sv
// Serialises a polygon header plus 3..MAX_VERTS vertices into VRAM as one
// contiguous parameter block and reports address, word count and skip.
module ta_param_writer
  import pvr_param_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_VERTS = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] param_base,
  input  logic [31:0]       isp_inst,
  input  logic [31:0]       tsp_inst,
  input  logic [31:0]       tex_cont,
  input  logic              shadow,
  input  logic [31:0]       tsp2_inst,
  input  logic [31:0]       tex2_cont,
  input  logic [3:0]        vert_count,
  input  logic              vert_valid,
  output logic              vert_ready,
  input  logic [31:0]       vert_x,
  input  logic [31:0]       vert_y,
  input  logic [31:0]       vert_z,
  input  logic [31:0]       vert_u0,
  input  logic [31:0]       vert_v0,
  input  logic [31:0]       vert_base_col,
  input  logic [31:0]       vert_off_col,
  output logic              ta_vram_wr,
  output logic [ADDR_W-1:0] ta_vram_addr,
  output logic [31:0]       ta_vram_dout,
  input  logic              ta_vram_wait,
  output logic              busy,
  output logic              poly_done,
  output logic [ADDR_W-1:0] poly_addr,
  output logic [6:0]        poly_words,
  output logic [2:0]        poly_skip
);

  localparam logic [3:0] MaxVerts = 4'(MAX_VERTS);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
  logic [31:0]       isp_q, isp_d, tsp_q, tsp_d, tex_q, tex_d, tsp2_q, tsp2_d, tex2_q, tex2_d;
  logic              shadow_q, shadow_d, texture_q, texture_d, offset_q, offset_d;
  logic              uv16_q, uv16_d;
  logic [3:0]        nverts_q, nverts_d, vcnt_q, vcnt_d;
  logic [2:0]        hidx_q, hidx_d, widx_q, widx_d;
  logic [6:0][31:0]  vtx_q, vtx_d;
  logic [ADDR_W-1:0] poly_addr_q, poly_addr_d;
  logic [6:0]        poly_words_q, poly_words_d;
  logic [2:0]        poly_skip_q, poly_skip_d;

  logic [31:0] hdr_data, sel_data;
  logic [2:0]  sel_next, vwords, hdr_last;
  logic        sel_last, accept;
  logic [3:0]  vc_clamped;
  logic        unused_base;

  assign unused_base = ^param_base[1:0];

  ta_word_sel u_word_sel (
    .idx_i      (widx_q),
    .texture_i  (texture_q),
    .offset_i   (offset_q),
    .uv16_i     (uv16_q),
    .words_i    (vtx_q),
    .data_o     (sel_data),
    .next_idx_o (sel_next),
    .last_o     (sel_last)
  );

  always_comb begin
    case (hidx_q)
      3'd0:    hdr_data = isp_q;
      3'd1:    hdr_data = tsp_q;
      3'd2:    hdr_data = tex_q;
      3'd3:    hdr_data = tsp2_q;
      3'd4:    hdr_data = tex2_q;
      default: hdr_data = 32'h0;
    endcase
  end

  assign vc_clamped = (vert_count < 4'd3) ? 4'd3 :
                      (vert_count > MaxVerts) ? MaxVerts : vert_count;
  assign vwords     = vtx_words(texture_q, offset_q, uv16_q);
  assign hdr_last   = (shadow_q ? HdrWordsShadow : HdrWordsPlain) - 3'd1;

  assign ta_vram_wr   = (state_q == StHdr) || (state_q == StVword);
  assign ta_vram_addr = addr_q;
  assign ta_vram_dout = (state_q == StHdr)   ? hdr_data :
                        (state_q == StVword) ? sel_data : 32'h0;
  assign accept       = ta_vram_wr & ~ta_vram_wait;
  assign vert_ready   = (state_q == StVwait);
  assign busy         = (state_q != StIdle);
  assign poly_done    = (state_q == StDone);
  assign poly_addr    = poly_addr_q;
  assign poly_words   = poly_words_q;
  assign poly_skip    = poly_skip_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    base_d       = base_q;
    isp_d        = isp_q;
    tsp_d        = tsp_q;
    tex_d        = tex_q;
    tsp2_d       = tsp2_q;
    tex2_d       = tex2_q;
    shadow_d     = shadow_q;
    texture_d    = texture_q;
    offset_d     = offset_q;
    uv16_d       = uv16_q;
    nverts_d     = nverts_q;
    vcnt_d       = vcnt_q;
    hidx_d       = hidx_q;
    widx_d       = widx_q;
    vtx_d        = vtx_q;
    poly_addr_d  = poly_addr_q;
    poly_words_d = poly_words_q;
    poly_skip_d  = poly_skip_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          base_d    = {param_base[ADDR_W-1:2], 2'b00};
          addr_d    = {param_base[ADDR_W-1:2], 2'b00};
          isp_d     = isp_inst;
          tsp_d     = tsp_inst;
          tex_d     = tex_cont;
          tsp2_d    = tsp2_inst;
          tex2_d    = tex2_cont;
          shadow_d  = shadow;
          texture_d = isp_inst[IspTextureBit];
          offset_d  = isp_inst[IspOffsetBit];
          uv16_d    = isp_inst[IspUv16Bit];
          nverts_d  = vc_clamped;
          vcnt_d    = 4'd0;
          hidx_d    = 3'd0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(4);
          if (hidx_q == hdr_last) state_d = StVwait;
          else                    hidx_d  = hidx_q + 3'd1;
        end
      end
      StVwait: begin
        if (vert_valid) begin
          vtx_d[SlotX]    = vert_x;
          vtx_d[SlotY]    = vert_y;
          vtx_d[SlotZ]    = vert_z;
          vtx_d[SlotU0]   = vert_u0;
          vtx_d[SlotV0]   = vert_v0;
          vtx_d[SlotBase] = vert_base_col;
          vtx_d[SlotOff]  = vert_off_col;
          widx_d          = SlotX;
          state_d         = StVword;
        end
      end
      StVword: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(4);
          if (sel_last) begin
            vcnt_d = vcnt_q + 4'd1;
            if (vcnt_q + 4'd1 == nverts_q) begin
              poly_addr_d  = base_q;
              poly_words_d = 7'(hdr_last + 3'd1) + 7'(nverts_q) * 7'(vwords);
              poly_skip_d  = vwords - 3'd3;
              state_d      = StDone;
            end else begin
              state_d = StVwait;
            end
          end else begin
            widx_d = sel_next;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      base_q       <= '0;
      isp_q        <= '0;
      tsp_q        <= '0;
      tex_q        <= '0;
      tsp2_q       <= '0;
      tex2_q       <= '0;
      shadow_q     <= 1'b0;
      texture_q    <= 1'b0;
      offset_q     <= 1'b0;
      uv16_q       <= 1'b0;
      nverts_q     <= '0;
      vcnt_q       <= '0;
      hidx_q       <= '0;
      widx_q       <= '0;
      vtx_q        <= '0;
      poly_addr_q  <= '0;
      poly_words_q <= '0;
      poly_skip_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      isp_q        <= isp_d;
      tsp_q        <= tsp_d;
      tex_q        <= tex_d;
      tsp2_q       <= tsp2_d;
      tex2_q       <= tex2_d;
      shadow_q     <= shadow_d;
      texture_q    <= texture_d;
      offset_q     <= offset_d;
      uv16_q       <= uv16_d;
      nverts_q     <= nverts_d;
      vcnt_q       <= vcnt_d;
      hidx_q       <= hidx_d;
      widx_q       <= widx_d;
      vtx_q        <= vtx_d;
      poly_addr_q  <= poly_addr_d;
      poly_words_q <= poly_words_d;
      poly_skip_q  <= poly_skip_d;
    end
  end

endmodule

// File: doc/ta_param_writer.md
Name: ta_param_writer

Overview:
- Writer end of the polygon parameter format consumed by the ISP parser.
- Takes a polygon header (ISP/TSP/TEX words) and a stream of 3..MAX_VERTS vertices, and serialises them into VRAM as one contiguous parameter block.
- The block layout is exactly the one the parser walks: header, then per-vertex x, y, z, [u0], [v0], base_col, [off_col].
- On completion it reports start address, word count and skip value so an object-list builder can emit the matching OPB word.

Parameters:
ADDR_W, 24, VRAM byte-address width; wraps modulo 2^ADDR_W.
MAX_VERTS, 8, maximum vertices per block (strip limit).

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: latch header and begin block; ignored while busy
param_base  in  ADDR_W  byte address of first word (word-aligned; bits[1:0] ignored, forced 0)
isp_inst  in  32  ISP word; decoded bits: texture=[25], offset=[24], uv_16_bit=[22]
tsp_inst  in  32  TSP word
tex_cont  in  32  texture control word
shadow  in  1  two-parameter header: also write tsp2_inst, tex2_cont
tsp2_inst  in  32  second TSP word
tex2_cont  in  32  second texture control word
vert_count  in  4  vertices in block; <3 treated as 3, >MAX_VERTS treated as MAX_VERTS
vert_valid  in  1  vertex bundle valid
vert_ready  out  1  vertex bundle accepted when valid&ready
vert_x, vert_y, vert_z, vert_u0, vert_v0, vert_base_col, vert_off_col  in  32 each  vertex words (u0 carries packed UV when uv_16_bit)
ta_vram_wr  out  1  write request
ta_vram_addr  out  ADDR_W  write byte address
ta_vram_dout  out  32  write data
ta_vram_wait  in  1  VRAM stall; word accepted on cycle with wr & !wait
busy  out  1  high from the cycle after an accepted start through the done pulse
poly_done  out  1  one-cycle pulse after the last word is accepted
poly_addr  out  ADDR_W  latched param_base, valid with poly_done
poly_words  out  7  total words written
poly_skip  out  3  per-vertex words minus 3 (OPB skip field)

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Header latch at accepted start: all header inputs, vert_count (after clamp), texture/offset/uv16.
- Derived counts:
  - vwords = 4 + texture*(2-uv_16_bit) + offset (range 4..7).
  - poly_skip = vwords-3.
  - hwords = 3 + 2*shadow.
  - poly_words = hwords + vert_count*vwords (max 61).
- State IDLE:
  - vert_ready=0, ta_vram_wr=0.
  - On start go to HDR; ta_vram_wr=1 and addr=param_base on the next cycle.
- State HDR:
  - Writes isp_inst, tsp_inst, tex_cont, then tsp2_inst, tex2_cont if shadow.
  - Address +4 per accepted word.
  - After the last header word goes to VWAIT.
- State VWAIT:
  - ta_vram_wr=0, vert_ready=1.
  - On valid&ready latch all seven vertex words into a holding register and go to VWORD.
  - vert_ready drops the cycle after acceptance.
- State VWORD:
  - Emits x, y, z; then u0 if texture; then v0 if texture & !uv_16_bit; then base_col; then off_col if offset.
  - Word index advances only on accepted words.
  - After the last word: vertex counter increments; goes to VWAIT if more vertices remain, else DONE.
- State DONE:
  - poly_done=1 for one cycle; poly_addr/poly_words/poly_skip hold until the next start.
  - busy drops with the pulse; returns to IDLE.
- Stall: while ta_vram_wait=1, ta_vram_wr, addr and data hold stable; no state advance.
- Address: 24-bit wrap, so 0xFFFFFC+4 = 0x000000. No error is flagged.
- start while busy: ignored, no effect on the current block.
- start in the same cycle as poly_done: ignored. A start is accepted in IDLE only.
- Reset mid-block: immediate abort. No done pulse; the partial block is left in VRAM.
- Two-volume parameters: not produced.

Decomposition:
- Shared package pvr_param_pkg holds:
  - ISP bit positions (texture 25, offset 24, uv_16_bit 22);
  - header/vertex word-count constants;
  - state enum (IDLE, HDR, VWAIT, VWORD, DONE).
- The parser should import the same constants.
- One natural sub-module: ta_word_sel (combinational vertex word-index to data mux with skip logic), used only by VWORD.

Test Plan:
- Untextured opaque triangle: isp_inst=0x00800000, base 0x000450, count 3, no wait -> 15 writes, 0x450..0x488; poly_words=15, poly_skip=1, poly_done once.
- Textured 32-bit UV plus offset, shadow=1, count 4 -> hwords 5, vwords 7, poly_words=33, poly_skip=4; word order verified per vertex.
- uv_16_bit textured strip, count 8 -> v0 never written, vwords 5, poly_words=43; vert_valid gapped randomly, data unaffected.
- ta_vram_wait asserted 3 cycles on every 2nd word -> addr/data stable during wait; no dropped or duplicated words.
- Boundaries:
  - base 0xFFFFF8 -> wraps to 0x000000.
  - vert_count=1 -> treated as 3.
  - vert_count=15 -> treated as 8.
  - start pulsed while busy -> ignored.
- reset_n low during VWORD of vertex 2 -> all outputs 0 immediately; poly_done never pulses; a new start then completes normally.
